// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//
// Bank of N independent down-counting timers. All channels share one tick
// strobe and one free-running tick prescaler. Each channel loads a value on
// timer_start and counts down once per prescaled step. It then either holds at
// zero (one-shot, level timer_up) or reloads (periodic, one-cycle expire_pulse
// on each expiry).
//
// Parameters:
//   W         counter width per channel
//   N         number of channels
//   PRESCALE  timer_tick strobes per count step (1..255)
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   timer_tick    shared one-cycle tick strobe
//   timer_start   [N]   per-channel load strobe
//   load_val      [N*W] channel i load value in [i*W +: W]
//   auto_reload   [N]   per-channel mode, sampled with timer_start (1 = periodic)
//   pause         [N]   per-channel freeze level
//   count         [N*W] channel i current count in [i*W +: W]
//   timer_up      [N]   high while channel count == 0
//   expire_pulse  [N]   one-cycle pulse on each expiry
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int W        = 7,
    parameter int N        = 2,
    parameter int PRESCALE = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           timer_tick,
    input  logic [N-1:0]   timer_start,
    input  logic [N*W-1:0] load_val,
    input  logic [N-1:0]   auto_reload,
    input  logic [N-1:0]   pause,
    output logic [N*W-1:0] count,
    output logic [N-1:0]   timer_up,
    output logic [N-1:0]   expire_pulse
);

    // The prescaler is at least 1 bit wide, even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [PW-1:0] prescaler_reg;
    logic          step;

    // Free-running and never cleared by a start. This means the first step
    // after a start can arrive up to PRESCALE-1 ticks early.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_reg <= '0;
        end else if (timer_tick) begin
            if (prescaler_reg == PS_LAST) begin
                prescaler_reg <= '0;
            end else begin
                prescaler_reg <= prescaler_reg + PW'(1);
            end
        end
    end

    assign step = timer_tick && (prescaler_reg == PS_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            logic [W-1:0] count_reg;
            logic [W-1:0] reload_reg;
            logic         mode_reg;
            logic         expire_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    // Channels come out of reset counting down from all-ones.
                    count_reg  <= '1;
                    reload_reg <= '1;
                    mode_reg   <= 1'b0;
                    expire_reg <= 1'b0;
                end else begin
                    // This is the default. It is overridden only on the edge
                    // where the channel expires, so the pulse is one cycle wide.
                    expire_reg <= 1'b0;
                    if (timer_start[gi]) begin
                        // A load beats both pause and a coincident step.
                        count_reg  <= load_val[gi*W +: W];
                        reload_reg <= load_val[gi*W +: W];
                        mode_reg   <= auto_reload[gi];
                    end else if (pause[gi]) begin
                        count_reg <= count_reg;
                    end else if (step && (count_reg == CNT_ONE)) begin
                        count_reg  <= mode_reg ? reload_reg : '0;
                        expire_reg <= 1'b1;
                    end else if (step && (count_reg != '0)) begin
                        count_reg <= count_reg - CNT_ONE;
                    end
                    // When count is zero, it saturates. A zero load never expires.
                end
            end

            assign count[gi*W +: W] = count_reg;
            assign timer_up[gi]     = (count_reg == '0);
            assign expire_pulse[gi] = expire_reg;
        end
    endgenerate

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
//
// Directed bench for timer_bank. dut_a is a 2-channel bank with PRESCALE=1 and
// covers the reset countdown, one-shot, priority, zero load, two-channel and
// asynchronous reset cases. dut_b is a 1-channel bank with PRESCALE=3 and
// covers the periodic mode behind the prescaler.
// -----------------------------------------------------------------------------
module tb_timer_bank;

    logic clk;
    logic reset_n;

    // dut_a: W=7, N=2, PRESCALE=1
    logic        a_tick;
    logic [1:0]  a_start;
    logic [13:0] a_load;
    logic [1:0]  a_auto;
    logic [1:0]  a_pause;
    logic [13:0] a_count;
    logic [1:0]  a_up;
    logic [1:0]  a_exp;

    // dut_b: W=7, N=1, PRESCALE=3
    logic        b_tick;
    logic [0:0]  b_start;
    logic [6:0]  b_load;
    logic [0:0]  b_auto;
    logic [0:0]  b_pause;
    logic [6:0]  b_count;
    logic [0:0]  b_up;
    logic [0:0]  b_exp;

    int checks;
    int errors;
    int s;
    int nexp;

    // Hand-computed two-channel sequence:
    // ch0 is a one-shot with load 3, and ch1 is periodic with load 2.
    logic [6:0] two_c0 [4];
    logic [6:0] two_c1 [4];
    logic [1:0] two_exp[4];
    logic [1:0] two_up [4];

    timer_bank #(.W(7), .N(2), .PRESCALE(1)) dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .timer_tick   (a_tick),
        .timer_start  (a_start),
        .load_val     (a_load),
        .auto_reload  (a_auto),
        .pause        (a_pause),
        .count        (a_count),
        .timer_up     (a_up),
        .expire_pulse (a_exp)
    );

    timer_bank #(.W(7), .N(1), .PRESCALE(3)) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .timer_tick   (b_tick),
        .timer_start  (b_start),
        .load_val     (b_load),
        .auto_reload  (b_auto),
        .pause        (b_pause),
        .count        (b_count),
        .timer_up     (b_up),
        .expire_pulse (b_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        nexp    = 0;
        two_c0  = '{7'd2, 7'd1, 7'd0, 7'd0};
        two_c1  = '{7'd1, 7'd2, 7'd1, 7'd2};
        two_exp = '{2'b00, 2'b10, 2'b01, 2'b10};
        two_up  = '{2'b00, 2'b00, 2'b01, 2'b01};

        reset_n = 1'b0;
        a_tick = 1'b0; a_start = '0; a_load = '0; a_auto = '0; a_pause = '0;
        b_tick = 1'b0; b_start = '0; b_load = '0; b_auto = '0; b_pause = '0;

        // Reset values
        #12;
        check("rst_count_a", 32'(a_count), 32'h3fff);
        check("rst_up_a",    32'(a_up),    32'h0);
        check("rst_exp_a",   32'(a_exp),   32'h0);
        check("rst_count_b", 32'(b_count), 32'd127);
        reset_n = 1'b1;
        cyc();
        check("idle_count_a", 32'(a_count), 32'h3fff);

        // Countdown from all-ones after reset
        for (int k = 1; k <= 127; k++) begin
            a_tick = 1'b1;
            cyc();
            check($sformatf("rst_cd_cnt0_t%0d", k), 32'(a_count[6:0]), 32'(127 - k));
            check($sformatf("rst_cd_exp_t%0d", k), 32'(a_exp), (k == 127) ? 32'h3 : 32'h0);
            check($sformatf("rst_cd_up_t%0d", k), 32'(a_up), (k == 127) ? 32'h3 : 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("sat_count", 32'(a_count), 32'h0);
            check("sat_up",    32'(a_up),    32'h3);
            check("sat_exp",   32'(a_exp),   32'h0);
        end
        a_tick = 1'b0;

        // One-shot with load 5
        a_start = 2'b01; a_load = {7'd0, 7'd5}; a_auto = 2'b00;
        cyc();
        a_start = 2'b00;
        check("os_load_cnt", 32'(a_count[6:0]), 32'd5);
        check("os_load_up",  32'(a_up[0]),      32'd0);
        for (int k = 1; k <= 5; k++) begin
            a_tick = 1'b1;
            cyc();
            check($sformatf("os_cnt_t%0d", k), 32'(a_count[6:0]), 32'(5 - k));
            check($sformatf("os_exp_t%0d", k), 32'(a_exp[0]), (k == 5) ? 32'd1 : 32'd0);
            check($sformatf("os_up_t%0d", k),  32'(a_up[0]),  (k == 5) ? 32'd1 : 32'd0);
        end
        a_tick = 1'b0;
        cyc();
        check("os_exp_drop", 32'(a_exp[0]), 32'd0);
        check("os_up_hold",  32'(a_up[0]),  32'd1);

        // Priority: start, step and pause in the same cycle
        a_start = 2'b01; a_load = {7'd0, 7'd9}; a_tick = 1'b1; a_pause = 2'b01;
        cyc();
        a_start = 2'b00;
        check("prio_load", 32'(a_count[6:0]), 32'd9);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check($sformatf("pause_hold_t%0d", k), 32'(a_count[6:0]), 32'd9);
        end
        a_pause = 2'b00; a_tick = 1'b0;

        // Zero load in periodic mode: no expiry pulse
        a_start = 2'b01; a_load = {7'd0, 7'd0}; a_auto = 2'b01;
        cyc();
        a_start = 2'b00;
        check("zero_cnt", 32'(a_count[6:0]), 32'd0);
        check("zero_up",  32'(a_up[0]),      32'd1);
        check("zero_exp", 32'(a_exp[0]),     32'd0);
        a_tick = 1'b1;
        cyc();
        a_tick = 1'b0;
        check("zero_step_cnt", 32'(a_count[6:0]), 32'd0);
        check("zero_step_exp", 32'(a_exp[0]),     32'd0);

        // Two channels started together
        a_start = 2'b11; a_load = {7'd2, 7'd3}; a_auto = 2'b10;
        cyc();
        a_start = 2'b00;
        check("two_load", 32'(a_count), 32'({7'd2, 7'd3}));
        for (int k = 0; k < 4; k++) begin
            a_tick = 1'b1;
            cyc();
            check($sformatf("two_c0_t%0d", k + 1), 32'(a_count[6:0]),  32'(two_c0[k]));
            check($sformatf("two_c1_t%0d", k + 1), 32'(a_count[13:7]), 32'(two_c1[k]));
            check($sformatf("two_exp_t%0d", k + 1), 32'(a_exp), 32'(two_exp[k]));
            check($sformatf("two_up_t%0d", k + 1),  32'(a_up),  32'(two_up[k]));
        end
        a_tick = 1'b0;

        // Mid-count asynchronous reset with a pulse in flight
        a_start = 2'b11; a_load = {7'd1, 7'd3}; a_auto = 2'b10;
        cyc();
        a_start = 2'b00;
        a_tick = 1'b1;
        cyc();
        a_tick = 1'b0;
        check("mr_pre_cnt0", 32'(a_count[6:0]), 32'd2);
        check("mr_pre_exp",  32'(a_exp),        32'h2);
        #3;
        reset_n = 1'b0;
        #1;
        check("mr_count", 32'(a_count), 32'h3fff);
        check("mr_exp",   32'(a_exp),   32'h0);
        check("mr_up",    32'(a_up),    32'h0);
        #1;
        reset_n = 1'b1;
        cyc();
        check("mr_after_count", 32'(a_count), 32'h3fff);

        // Periodic with PRESCALE=3: load 4, 36 ticks -> 12 steps, 3 pulses
        check("b_rst_count", 32'(b_count), 32'd127);
        b_start = 1'b1; b_load = 7'd4; b_auto = 1'b1;
        cyc();
        b_start = 1'b0;
        check("b_load", 32'(b_count), 32'd4);
        for (int k = 1; k <= 36; k++) begin
            b_tick = 1'b1;
            cyc();
            s = k / 3;
            check($sformatf("b_cnt_t%0d", k), 32'(b_count),
                  ((s % 4) == 0) ? 32'd4 : 32'(4 - (s % 4)));
            check($sformatf("b_exp_t%0d", k), 32'(b_exp),
                  (((k % 3) == 0) && ((s % 4) == 0)) ? 32'd1 : 32'd0);
            check($sformatf("b_up_t%0d", k), 32'(b_up), 32'd0);
            if (b_exp[0] === 1'b1) nexp++;
        end
        b_tick = 1'b0;
        check("b_pulse_total", 32'(nexp), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
